spi_byte_receiver: RTL
======================

# spi_byte_receiver

- Receive-side SPI endpoint in the AXI-Lite-to-SPI design, the counterpart of the SPI byte writer.
- Oversamples SCK, CS_N and MOSI in the system clock domain and assembles MSB-first bytes.
- Buffers received bytes in a small FIFO and presents them over a valid/ready interface.
- Flags overrun and truncated frames.
- Used as the loopback/peripheral model and as the MOSI capture path for readback.

## Interface
Parameters:
- DEPTH, 4 — FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2 — synchronizer flops on SCK, CS_N and MOSI; minimum 2.

Ports:
- CLK  in  1  system clock; must be at least 4x SCK frequency.
- RST  in  1  reset: synchronous, active-high.
- SCK  in  1  SPI clock, asynchronous to CLK, idle low.
- CS_N  in  1  chip select, active-low, asynchronous.
- MOSI  in  1  serial data; changes on falling SCK, sampled on rising SCK.
- RX_DATA  out  8  FIFO head byte; 0 when the FIFO is empty.
- RX_VALID  out  1  FIFO not empty.
- RX_READY  in  1  consumer pop; a pop occurs when RX_VALID && RX_READY.
- LEVEL  out  $clog2(DEPTH+1)  FIFO occupancy.
- FRAME_END  out  1  one-CLK pulse on CS_N deassertion.
- FRAME_ERR  out  1  sticky: CS_N rose with a partial byte.
- OVERRUN  out  1  sticky: a byte completed while the FIFO was full.
- ERR_CLR  in  1  clears FRAME_ERR and OVERRUN.

## Operation
- Inputs are synchronized through SYNC_STAGES flops each, equal depth, so SCK/MOSI alignment is preserved.
- One extra flop on synced SCK and CS_N provides edge detection.
- State machine:
  - HUNT (reset state): wait for synced CS_N high, then go to IDLE. Prevents capturing a misaligned byte when reset releases mid-frame.
  - IDLE: on synced CS_N falling, clear the bit counter and shift register, then go to SHIFT.
  - SHIFT: on each synced SCK rising edge, shift register = {sr[6:0], MOSI_sync} and the counter increments. When the counter wraps from 7 to 0, the assembled byte is pushed to the FIFO.
    - CS_N may stay low for any number of consecutive bytes.
    - On synced CS_N rising: pulse FRAME_END and go to IDLE.
    - If the counter is nonzero at that point, discard the partial byte and set FRAME_ERR.
- SCK edges while CS_N is high are ignored.
- FIFO behaviour:
  - Circular buffer with read/write pointers one bit wider than the index.
  - Full when the index bits are equal and the MSBs differ; empty when all bits are equal.
- Push when full is dropped and sets OVERRUN; stored data is unchanged.
- Push and pop in the same cycle:
  - When full, the pop frees the slot and the push is accepted; LEVEL is unchanged and there is no overrun.
  - When empty, the push lands and RX_VALID rises the next cycle; there is no pop of nonexistent data.
- ERR_CLR in the same cycle as a new error event: the set wins.
- RST mid-frame: FIFO flushed, pointers, counter, shift register and stickies cleared, state goes to HUNT.

## Timing
- All outputs are registered. Reset values:
  - RX_DATA 0, RX_VALID 0, LEVEL 0.
  - FRAME_END 0, FRAME_ERR 0, OVERRUN 0.
  - State HUNT.
- Latency from the 8th SCK rising pin edge to RX_VALID high:
  - SYNC_STAGES+2 CLK cycles, i.e. 4 at default.
  - Breakdown: SYNC_STAGES to sync, 1 to edge-detect and push, 1 to update the status register.
- FRAME_END is asserted SYNC_STAGES+2 cycles after the CS_N rising pin edge, for exactly 1 cycle.
- FRAME_ERR and OVERRUN become visible in the same cycle FRAME_END or the push would have occurred.
- Pop: RX_DATA and RX_VALID reflect the next entry in the cycle after the pop; LEVEL decrements the same cycle.
- Input SCK high and low phases must each be at least 2 CLK periods. Behaviour is undefined otherwise.

## Structure
- Shared package spi_pkg holds:
  - SPI_BYTE_W = 8.
  - The state enum encoding (HUNT=2'd0, IDLE=2'd1, SHIFT=2'd2).
  - The SPI mode constant (CPOL=0, CPHA=0), shared with the writer.
- One sub-module: spi_rx_fifo (parameter DEPTH, width 8), containing push/pop/full/empty/level logic.
- Synchronizers and the FSM stay in the top module.

## Test plan
- Single byte: CS_N low, send 0xA5 MSB first at CLK/8, CS_N high.
  - RX_DATA=0xA5 and RX_VALID 4 cycles after the 8th rising edge.
  - FRAME_END one pulse; FRAME_ERR=0.
- Burst: 3 bytes 0x01, 0x80, 0xFF under one CS_N low with RX_READY=0.
  - LEVEL=3; then popping returns 0x01, 0x80, 0xFF in order, with LEVEL 2, 1, 0.
- Overrun: DEPTH=4, 6 bytes 0x10..0x15 with RX_READY=0.
  - FIFO holds 0x10..0x13; OVERRUN=1.
  - ERR_CLR clears it.
- Truncated frame: 5 bits then CS_N high, followed by a full byte 0x3C.
  - FRAME_ERR=1 and no push for the truncated byte; next pop returns 0x3C.
- Full with simultaneous pop: FIFO full, RX_READY=1 in the cycle the 4th-next byte 0x77 completes.
  - LEVEL stays 4, OVERRUN=0, and 0x77 is popped last.
- Reset mid-frame: RST after 3 bits with CS_N held low, then 8 more bits.
  - Nothing is pushed (HUNT) until CS_N goes high and a new frame delivers 0x5A.
  - All outputs are 0 during and after RST.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the AXI-Lite-to-SPI design (byte writer and byte receiver).
// Contents: byte width, SPI mode constants and the receiver FSM state encoding.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    // Mode 0: SCK idles low, data is sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        StHunt  = 2'd0,
        StIdle  = 2'd1,
        StShift = 2'd2
    } rx_state_e;

endpackage

// File: rtl/spi_byte_receiver_if.sv
// Bus bundle for spi_byte_receiver: SPI pins, the received-byte valid/ready
// stream, and the status/error flags.
//   slave  : the receiver (SPI pins and RX_READY/ERR_CLR in, stream and status out)
//   master : the SPI driver plus byte consumer
interface spi_byte_receiver_if #(
    parameter int unsigned DEPTH = 4
) ();
    import spi_pkg::*;

    logic                         SCK;
    logic                         CS_N;
    logic                         MOSI;
    logic [SPI_BYTE_W-1:0]        RX_DATA;
    logic                         RX_VALID;
    logic                         RX_READY;
    logic [$clog2(DEPTH+1)-1:0]   LEVEL;
    logic                         FRAME_END;
    logic                         FRAME_ERR;
    logic                         OVERRUN;
    logic                         ERR_CLR;

    modport slave (
        input  SCK, CS_N, MOSI, RX_READY, ERR_CLR,
        output RX_DATA, RX_VALID, LEVEL, FRAME_END, FRAME_ERR, OVERRUN
    );

    modport master (
        output SCK, CS_N, MOSI, RX_READY, ERR_CLR,
        input  RX_DATA, RX_VALID, LEVEL, FRAME_END, FRAME_ERR, OVERRUN
    );

endinterface

// File: rtl/spi_rx_fifo.sv
// Received-byte FIFO with registered head/valid/level outputs.
//   CLK, RST     : system clock, synchronous active-high reset
//   push_i       : write request with push_data_i
//   ready_i      : consumer ready; a pop happens when valid_o && ready_i
//   data_o       : head byte (0 when empty), valid_o : not empty, level_o : occupancy
//   overflow_o   : combinational, a push was dropped this cycle because the FIFO was full
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push_i,
    input  logic [SPI_BYTE_W-1:0]      push_data_i,
    input  logic                       ready_i,
    output logic [SPI_BYTE_W-1:0]      data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [SPI_BYTE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_q, level_d;
    logic [SPI_BYTE_W-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  full, pop, push_ok;

    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop     = valid_q && ready_i;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok = push_i && (!full || pop);
    assign overflow_o = push_i && !push_ok;

    assign wr_ptr_d = wr_ptr_q + PW'(push_ok);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);

    // Outputs are registered from the post-update pointers so a pop is reflected
    // in the very next cycle and the consumer never sees a stale valid.
    always_comb begin
        level_d = wr_ptr_d - rd_ptr_d;
        valid_d = (wr_ptr_d != rd_ptr_d);
        data_d  = '0;
        if (valid_d) begin
            // New head is the byte being written this cycle (FIFO was empty).
            if (push_ok && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
                data_d = push_data_i;
            end else begin
                data_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign level_o = level_q;

endmodule

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 byte receiver: oversamples SCK/CS_N/MOSI on CLK, assembles MSB-first
// bytes and queues them in spi_rx_fifo.
//   CLK, RST : system clock (>= 4x SCK), synchronous active-high reset
//   bus      : SPI pins, RX valid/ready stream, LEVEL, FRAME_END pulse,
//              sticky FRAME_ERR/OVERRUN cleared by ERR_CLR
module spi_byte_receiver
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    spi_byte_receiver_if.slave bus
);

    localparam logic SampleRising = (SPI_CPOL == SPI_CPHA);

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_d_q, cs_d_q;
    logic                   sck_s, cs_s, mosi_s, sck_edge, cs_rise, cs_fall;

    rx_state_e             state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [SPI_BYTE_W-1:0] sr_q, sr_d, byte_q, byte_d;
    logic                  push_q, push_d;
    logic                  fe_evt_q, fe_evt_d, ferr_evt_q, ferr_evt_d;
    logic                  frame_end_q, frame_err_q, overrun_q;
    logic                  fifo_overflow;

    // Equal-depth synchronizers keep MOSI aligned with the SCK edge it belongs to.
    // CS sync resets low so HUNT only leaves once the real pin is seen high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_d_q     <= 1'b0;
            cs_d_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
            sck_d_q     <= sck_s;
            cs_d_q      <= cs_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_edge = SampleRising ? (sck_s && !sck_d_q) : (!sck_s && sck_d_q);
    assign cs_rise  = cs_s && !cs_d_q;
    assign cs_fall  = !cs_s && cs_d_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        byte_d     = byte_q;
        push_d     = 1'b0;
        fe_evt_d   = 1'b0;
        ferr_evt_d = 1'b0;
        unique case (state_q)
            StHunt: begin
                if (cs_s) state_d = StIdle;
            end
            StIdle: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    sr_d    = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // CS_N release wins over a coincident SCK edge; any partial byte is dropped.
                if (cs_rise) begin
                    fe_evt_d   = 1'b1;
                    ferr_evt_d = (cnt_q != 3'd0);
                    cnt_d      = '0;
                    sr_d       = '0;
                    state_d    = StIdle;
                end else if (sck_edge) begin
                    sr_d  = {sr_q[SPI_BYTE_W-2:0], mosi_s};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        push_d = 1'b1;
                        byte_d = {sr_q[SPI_BYTE_W-2:0], mosi_s};
                    end
                end
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StHunt;
            cnt_q      <= '0;
            sr_q       <= '0;
            byte_q     <= '0;
            push_q     <= 1'b0;
            fe_evt_q   <= 1'b0;
            ferr_evt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            byte_q     <= byte_d;
            push_q     <= push_d;
            fe_evt_q   <= fe_evt_d;
            ferr_evt_q <= ferr_evt_d;
        end
    end

    // Status stage: lines up FRAME_END/FRAME_ERR/OVERRUN with the FIFO's registered outputs.
    // A new error event takes priority over ERR_CLR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_end_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_end_q <= fe_evt_q;
            frame_err_q <= ferr_evt_q || (frame_err_q && !bus.ERR_CLR);
            overrun_q   <= fifo_overflow || (overrun_q && !bus.ERR_CLR);
        end
    end

    spi_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (push_q),
        .push_data_i (byte_q),
        .ready_i     (bus.RX_READY),
        .data_o      (bus.RX_DATA),
        .valid_o     (bus.RX_VALID),
        .level_o     (bus.LEVEL),
        .overflow_o  (fifo_overflow)
    );

    assign bus.FRAME_END = frame_end_q;
    assign bus.FRAME_ERR = frame_err_q;
    assign bus.OVERRUN   = overrun_q;

endmodule
